// File: rtl/iter_ctrl_pkg.sv
// Shared definitions for the iteration controller: state encoding and parameter range limits.
package iter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REL = 3'd1,
    ST_LOAD     = 3'd2,
    ST_STEP     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int unsigned CNT_W_MIN       = 1;
  localparam int unsigned CNT_W_MAX       = 31;
  localparam int unsigned LOAD_CYCLES_MIN = 1;

  // Largest value an unsigned counter of width w can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Saturating up-counter with synchronous clear and an equality compare
// against a programmable terminal value.
module iter_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit_c
);

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit_c = (cnt == term);

endmodule

// File: rtl/iter_ctrl.sv
// Start/load/iterate sequencer for the shift/normalise datapath.
// Optional iteration limit and timeout flag: define ITER_TIMEOUT_EN.
module iter_ctrl
  import iter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned LOAD_CYCLES = 1,
  parameter int unsigned MAX_ITER    = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             zer,
  output logic             wen,
  output logic             wenep,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
`ifdef ITER_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
    $error("iter_ctrl: CNT_W out of range");
  end
  if ((LOAD_CYCLES < LOAD_CYCLES_MIN) || (LOAD_CYCLES > cnt_max(CNT_W))) begin : g_bad_load
    $error("iter_ctrl: LOAD_CYCLES out of range");
  end
  if (MAX_ITER > cnt_max(CNT_W)) begin : g_bad_max_iter
    $error("iter_ctrl: MAX_ITER out of range");
  end

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);

  state_t           state, state_nxt;
  logic             cnt_clr, cnt_inc, cnt_hit_c, limit_c;
  logic [CNT_W-1:0] term;

  // One counter serves both the load-cycle count and the iteration count.
  iter_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (term),
    .cnt   (iter_cnt),
    .hit_c (cnt_hit_c)
  );

`ifdef ITER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MAX_ITER);
  assign term    = (state == ST_LOAD) ? LOAD_LAST : ITER_LAST;
  assign limit_c = cnt_hit_c;

  // Sticky until the next operation leaves WAIT_REL for LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if ((state == ST_STEP) && !zer && limit_c) begin
      timeout <= 1'b1;
    end else if ((state == ST_WAIT_REL) && !start) begin
      timeout <= 1'b0;
    end
  end
`else
  assign term    = LOAD_LAST;
  assign limit_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs; only STEP writes depend on zer.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wen       = 1'b0;
    wenep     = 1'b0;
    sel       = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!start) begin
          state_nxt = ST_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        sel = 1'b1;
        wen = 1'b1;
        if (cnt_hit_c) begin
          state_nxt = ST_STEP;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_STEP: begin
        if (zer || limit_c) begin
          state_nxt = ST_DONE;
        end else begin
          wen     = 1'b1;
          wenep   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iter_ctrl.sv
// Directed bench for iter_ctrl: three instances cover LOAD_CYCLES=1, LOAD_CYCLES=4 and CNT_W=3.
module tb_iter_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, zer0, wen0, wenep0, sel0, busy0, done0;
  logic [4:0] cnt0;
  logic start4, zer4, wen4, wenep4, sel4, busy4, done4;
  logic [4:0] cnt4;
  logic start3, zer3, wen3, wenep3, sel3, busy3, done3;
  logic [2:0] cnt3;
`ifdef ITER_TIMEOUT_EN
  logic to0, to4, to3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  iter_ctrl #(.CNT_W(5), .LOAD_CYCLES(1), .MAX_ITER(31)) u0 (
    .clk(clk), .rst(rst), .start(start0), .zer(zer0), .wen(wen0), .wenep(wenep0),
    .sel(sel0), .busy(busy0), .done(done0), .iter_cnt(cnt0)
`ifdef ITER_TIMEOUT_EN
    , .timeout(to0)
`endif
  );

  iter_ctrl #(.CNT_W(5), .LOAD_CYCLES(4), .MAX_ITER(31)) u4 (
    .clk(clk), .rst(rst), .start(start4), .zer(zer4), .wen(wen4), .wenep(wenep4),
    .sel(sel4), .busy(busy4), .done(done4), .iter_cnt(cnt4)
`ifdef ITER_TIMEOUT_EN
    , .timeout(to4)
`endif
  );

  iter_ctrl #(.CNT_W(3), .LOAD_CYCLES(1), .MAX_ITER(7)) u3 (
    .clk(clk), .rst(rst), .start(start3), .zer(zer3), .wen(wen3), .wenep(wenep3),
    .sel(sel3), .busy(busy3), .done(done3), .iter_cnt(cnt3)
`ifdef ITER_TIMEOUT_EN
    , .timeout(to3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b0;
    start0 = 0; zer0 = 0; start4 = 0; zer4 = 0; start3 = 0; zer3 = 0;
    #3;
    check("rst_wen", wen0, 0);
    check("rst_wenep", wenep0, 0);
    check("rst_sel", sel0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_cnt", cnt0, 0);
    step();
    rst = 1'b1;
    step();

    // LOAD_CYCLES=1: start held 3 cycles, three STEP writes, then zer
    start0 = 1; step();
    check("u0_busy_rise", busy0, 1);
    check("u0_wait_sel", sel0, 0);
    step(); step();
    check("u0_wait_busy", busy0, 1);
    start0 = 0; step();
    check("u0_load_sel", sel0, 1);
    check("u0_load_wen", wen0, 1);
    check("u0_load_wenep", wenep0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      zer0 = (i == 3); #1;
      check("u0_step_cnt", cnt0, i);
      check("u0_step_sel", sel0, 0);
      check("u0_step_wen", wen0, (i < 3));
      check("u0_step_wenep", wenep0, (i < 3));
      check("u0_step_done", done0, 0);
      step();
    end
    check("u0_done", done0, 1);
    check("u0_done_cnt", cnt0, 3);
    check("u0_done_wen", wen0, 0);
    step();
    check("u0_idle_done", done0, 0);
    check("u0_idle_busy", busy0, 0);
    check("u0_idle_cnt", cnt0, 3);

    // start toggled in STEP and DONE: no restart
    zer0 = 0; start0 = 1; step();
    start0 = 0; step();
    step();
    start0 = 1; step();
    check("u0_tog_cnt1", cnt0, 1);
    check("u0_tog_busy", busy0, 1);
    check("u0_tog_sel", sel0, 0);
    start0 = 0; step();
    check("u0_tog_cnt2", cnt0, 2);
    zer0 = 1; start0 = 1; step();
    check("u0_tog_done", done0, 1);
    step();
    start0 = 0;
    check("u0_tog_idle_busy", busy0, 0);
    check("u0_tog_idle_done", done0, 0);
    check("u0_tog_idle_cnt", cnt0, 2);
    step();
    check("u0_tog_stay_busy", busy0, 0);
    check("u0_tog_stay_done", done0, 0);

    // reset while in STEP with iter_cnt=2
    zer0 = 0; start0 = 1; step();
    start0 = 0; step();
    step(); step(); step();
    check("u0_pre_rst_cnt", cnt0, 2);
    check("u0_pre_rst_wen", wen0, 1);
    rst = 1'b0; #1;
    check("u0_rst_cnt", cnt0, 0);
    check("u0_rst_busy", busy0, 0);
    check("u0_rst_wen", wen0, 0);
    check("u0_rst_wenep", wenep0, 0);
    step();
    check("u0_rst_hold_busy", busy0, 0);
    check("u0_rst_hold_cnt", cnt0, 0);
    check("u0_rst_hold_sel", sel0, 0);
    rst = 1'b1;
    step();

    // LOAD_CYCLES=4 with zer=1 on STEP entry: done in the 6th cycle after release
    start4 = 1; step();
    start4 = 0; zer4 = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("u4_sel", sel4, (i < 4));
      check("u4_wen", wen4, (i < 4));
      check("u4_wenep", wenep4, 0);
      check("u4_done", done4, (i == 5));
      check("u4_cnt", cnt4, (i < 4) ? i : 0);
    end
    step();
    check("u4_end_busy", busy4, 0);
    check("u4_end_cnt", cnt4, 0);

    // CNT_W=3 with zer held 0
    start3 = 1; step();
    start3 = 0; zer3 = 0; step();
    check("u3_load_sel", sel3, 1);
    step();
`ifndef ITER_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      check("u3_sat_cnt", cnt3, (i < 7) ? i : 7);
      check("u3_sat_wen", wen3, 1);
      check("u3_sat_wenep", wenep3, 1);
      step();
    end
    check("u3_sat_cnt_end", cnt3, 7);
    check("u3_sat_busy", busy3, 1);
    zer3 = 1; #1;
    check("u3_zer_wen", wen3, 0);
    step();
    check("u3_done", done3, 1);
    check("u3_done_cnt", cnt3, 7);
`else
    for (int i = 0; i < 7; i++) begin
      check("u3_to_cnt", cnt3, i);
      check("u3_to_wen", wen3, 1);
      check("u3_to_wenep", wenep3, 1);
      step();
    end
    check("u3_to_limit_wen", wen3, 0);
    check("u3_to_limit_cnt", cnt3, 7);
    step();
    check("u3_to_done", done3, 1);
    check("u3_to_flag", to3, 1);
    step();
    check("u3_to_idle_flag", to3, 1);
    check("u3_to_idle_busy", busy3, 0);
    start3 = 1; step();
    check("u3_to_wait_flag", to3, 1);
    start3 = 0; zer3 = 1; step();
    check("u3_to_load_flag", to3, 0);
    step(); step();
    check("u3_to_done2", done3, 1);
    check("u3_to_flag2", to3, 0);
    check("u0_to_flag", to0, 0);
    check("u4_to_flag", to4, 0);
`endif
    step();
    check("u3_end_busy", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
